// File: rtl/stopwatch_mode_sequencer_pkg.sv
// Shared encodings for the stopwatch mode sequencer: states, display sources and
// auto-repeat timing (used only when AUTO_REPEAT_EN is defined).
package stopwatch_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      RUN      = 3'd1,
      PAUSE    = 3'd2,
      LAP      = 3'd3,
      SET_HOUR = 3'd4,
      SET_MIN  = 3'd5
   } state_t;

   localparam logic [1:0] DISP_LIVE = 2'b00;
   localparam logic [1:0] DISP_LAP  = 2'b01;
   localparam logic [1:0] DISP_SET  = 2'b10;

   localparam int RPT_HOLD_TICKS   = 50;
   localparam int RPT_PERIOD_TICKS = 25;

   function automatic logic is_set(state_t s);
      return (s == SET_HOUR) || (s == SET_MIN);
   endfunction

endpackage

// File: rtl/stopwatch_mode_sequencer_if.sv
// Button/tick inputs and control outputs of the mode sequencer, bundled for the
// debounce stage (master) and the sequencer (slave).
interface stopwatch_mode_sequencer_if;
   logic       tick;
   logic       start_p;
   logic       lap_p;
   logic       lap_lvl;
   logic       set_sw;
   logic       count_en;
   logic       count_clr;
   logic       lap_capture;
   logic [1:0] disp_sel;
   logic       inc_hour;
   logic       inc_min;
   logic       blink;
   logic [2:0] state;

   modport master (
      output tick, start_p, lap_p, lap_lvl, set_sw,
      input  count_en, count_clr, lap_capture, disp_sel, inc_hour, inc_min, blink, state
   );

   modport slave (
      input  tick, start_p, lap_p, lap_lvl, set_sw,
      output count_en, count_clr, lap_capture, disp_sel, inc_hour, inc_min, blink, state
   );
endinterface

// File: rtl/stopwatch_mode_sequencer_tick_timer.sv
// Saturating tick counter; hit_o flags the enable that carries the count onto THRESH.
module tick_timer #(
   parameter int CNT_W  = 16,
   parameter int THRESH = 200
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr_i,
   input  logic en_i,
   output logic hit_o
);
   localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(THRESH - 1);
   localparam logic [CNT_W-1:0] TOP  = CNT_W'(THRESH);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)                    cnt_d = '0;
      else if (en_i && cnt_q != TOP) cnt_d = cnt_q + ONE;
   end

   always_ff @(posedge clk) begin
      if (rst_n) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   // Once saturated the count no longer passes LAST, so a hold can hit only once.
   assign hit_o = en_i && (cnt_q == LAST);
endmodule

// File: rtl/stopwatch_mode_sequencer.sv
// Central stopwatch/clock mode FSM. rst_n is active-high despite its name.
// Optional AUTO_REPEAT_EN: holding lap in a set mode auto-repeats the increment.
module stopwatch_mode_sequencer
   import stopwatch_pkg::*;
#(
   parameter int LONG_PRESS_TICKS  = 200,
   parameter int SET_TIMEOUT_TICKS = 1000,
   parameter int BLINK_TICKS       = 50,
   parameter int CNT_W             = 16
) (
   input logic                       clk,
   input logic                       rst_n,
   stopwatch_mode_sequencer_if.slave sw
);
   state_t     state_q, state_d;
   logic       pause_lap_q, pause_lap_d;
   logic       count_en_q, count_en_d;
   logic       count_clr_q, count_clr_d;
   logic       lap_cap_q, lap_cap_d;
   logic [1:0] disp_q, disp_d;
   logic       inc_hour_q, inc_hour_d;
   logic       inc_min_q, inc_min_d;
   logic       blink_q, blink_d;

   logic in_set_q, lp_hit, to_hit, bl_hit, rpt_hit, inc_req;

   assign in_set_q = is_set(state_q);

   tick_timer #(.CNT_W(CNT_W), .THRESH(LONG_PRESS_TICKS)) u_long (
      .clk(clk), .rst_n(rst_n), .clr_i(!sw.lap_lvl),
      .en_i(sw.tick && sw.lap_lvl && state_q == PAUSE), .hit_o(lp_hit));

   tick_timer #(.CNT_W(CNT_W), .THRESH(SET_TIMEOUT_TICKS)) u_timeout (
      .clk(clk), .rst_n(rst_n),
      .clr_i(!in_set_q || sw.start_p || sw.lap_p || rpt_hit),
      .en_i(sw.tick), .hit_o(to_hit));

   tick_timer #(.CNT_W(CNT_W), .THRESH(BLINK_TICKS)) u_blink (
      .clk(clk), .rst_n(rst_n), .clr_i(!in_set_q || bl_hit),
      .en_i(sw.tick), .hit_o(bl_hit));

`ifdef AUTO_REPEAT_EN
   logic rpt_on_q, hold_hit, per_hit;

   tick_timer #(.CNT_W(CNT_W), .THRESH(RPT_HOLD_TICKS)) u_rpt_hold (
      .clk(clk), .rst_n(rst_n), .clr_i(!sw.lap_lvl || !in_set_q),
      .en_i(sw.tick), .hit_o(hold_hit));

   tick_timer #(.CNT_W(CNT_W), .THRESH(RPT_PERIOD_TICKS)) u_rpt_period (
      .clk(clk), .rst_n(rst_n), .clr_i(!rpt_on_q || per_hit),
      .en_i(sw.tick), .hit_o(per_hit));

   always_ff @(posedge clk) begin
      if (rst_n) rpt_on_q <= 1'b0;
      else       rpt_on_q <= (rpt_on_q || hold_hit) && sw.lap_lvl && in_set_q;
   end

   assign rpt_hit = hold_hit || per_hit;
`else
   assign rpt_hit = 1'b0;
`endif

   assign inc_req = sw.lap_p || rpt_hit;

   always_ff @(posedge clk) begin
      if (rst_n) begin
         state_q     <= IDLE;
         pause_lap_q <= 1'b0;
         count_en_q  <= 1'b0;
         count_clr_q <= 1'b0;
         lap_cap_q   <= 1'b0;
         disp_q      <= DISP_LIVE;
         inc_hour_q  <= 1'b0;
         inc_min_q   <= 1'b0;
         blink_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         pause_lap_q <= pause_lap_d;
         count_en_q  <= count_en_d;
         count_clr_q <= count_clr_d;
         lap_cap_q   <= lap_cap_d;
         disp_q      <= disp_d;
         inc_hour_q  <= inc_hour_d;
         inc_min_q   <= inc_min_d;
         blink_q     <= blink_d;
      end
   end

   // start_p is tested first everywhere, so a coincident lap_p is dropped.
   always_comb begin
      state_d     = state_q;
      count_clr_d = 1'b0;
      lap_cap_d   = 1'b0;
      inc_hour_d  = 1'b0;
      inc_min_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (sw.start_p)     state_d = RUN;
            else if (sw.set_sw) state_d = SET_HOUR;
         end
         RUN: begin
            if (sw.start_p) state_d = PAUSE;
            else if (sw.lap_p) begin
               state_d   = LAP;
               lap_cap_d = 1'b1;
            end
         end
         LAP: begin
            if (sw.start_p)    state_d = PAUSE;
            else if (sw.lap_p) state_d = RUN;
         end
         PAUSE: begin
            if (sw.start_p) state_d = RUN;
            else if (lp_hit) begin
               state_d     = IDLE;
               count_clr_d = 1'b1;
            end else if (sw.set_sw) state_d = SET_HOUR;
         end
         SET_HOUR, SET_MIN: begin
            if (!sw.set_sw)     state_d = IDLE;
            else if (sw.start_p) state_d = (state_q == SET_HOUR) ? SET_MIN : SET_HOUR;
            else if (inc_req) begin
               inc_hour_d = (state_q == SET_HOUR);
               inc_min_d  = (state_q == SET_MIN);
            end else if (to_hit) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      count_en_d  = (state_d == RUN) || (state_d == LAP);
      pause_lap_d = (state_d == PAUSE) && ((state_q == LAP) || pause_lap_q);
      case (state_d)
         LAP:               disp_d = DISP_LAP;
         PAUSE:             disp_d = pause_lap_d ? DISP_LAP : DISP_LIVE;
         SET_HOUR, SET_MIN: disp_d = DISP_SET;
         default:           disp_d = DISP_LIVE;
      endcase
      blink_d = 1'b0;
      if (is_set(state_d)) begin
         if (!in_set_q)   blink_d = 1'b1;
         else if (bl_hit) blink_d = !blink_q;
         else             blink_d = blink_q;
      end
   end

   assign sw.state       = state_q;
   assign sw.count_en    = count_en_q;
   assign sw.count_clr   = count_clr_q;
   assign sw.lap_capture = lap_cap_q;
   assign sw.disp_sel    = disp_q;
   assign sw.inc_hour    = inc_hour_q;
   assign sw.inc_min     = inc_min_q;
   assign sw.blink       = blink_q;
endmodule
